// File: rtl/ram2_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ram2_pkg
// Purpose : Shared defaults, clear-sequencer state type and the saturating
//           increment helper for the ram2_responder slice.
// Rev     : 1.0  initial release
// ============================================================================
package ram2_pkg;

  localparam int C_ADDR_W = 5;
  localparam int C_DATA_W = 32;
  localparam int C_DEPTH  = 32;
  localparam int C_CNT_W  = 16;

  // Clear sequencer: idle, or walking the array writing zeros
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Increment v, holding at 2**width-1 (width must be 1..32)
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int width);
    logic [32:0] w_max;
    w_max = (33'd1 << width) - 33'd1;
    if ({1'b0, v} >= w_max) return v;
    return v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram2_array.sv
`default_nettype none
// ============================================================================
// Module  : ram2_array
// Purpose : Word storage with three combinational read taps and prioritised
//           writes: port A (debug, else clear-zero) beats port B (functional).
//           Storage has no reset so debug preloads survive rst.
// Rev     : 1.0  initial release
// ============================================================================
module ram2_array
  import ram2_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W,
  parameter int DATA_W = C_DATA_W,
  parameter int DEPTH  = C_DEPTH
) (
  input  logic              clk,
  // port A: debug write, with the clear sequencer as lower-priority source
  input  logic              i_dbg_en,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_data,
  input  logic              i_clr_en,
  input  logic [ADDR_W-1:0] i_clr_addr,
  // port B: functional write
  input  logic              i_fn_en,
  input  logic [ADDR_W-1:0] i_fn_addr,
  input  logic [DATA_W-1:0] i_fn_data,
  // read taps
  input  logic [ADDR_W-1:0] i_raddr0,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rd0,
  output logic [DATA_W-1:0] o_rd1,
  output logic [DATA_W-1:0] o_rd2
);

  localparam logic [ADDR_W:0] c_depth_ext = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < c_depth_ext);
  endfunction

  // Per-word write with priority debug > clear > functional; out-of-range
  // addresses match no word and are therefore silently ignored.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (i_dbg_en && (i_dbg_addr == ADDR_W'(i))) begin
        r_mem[i] <= i_dbg_data;
      end else if (i_clr_en && (i_clr_addr == ADDR_W'(i))) begin
        r_mem[i] <= '0;
      end else if (i_fn_en && (i_fn_addr == ADDR_W'(i))) begin
        r_mem[i] <= i_fn_data;
      end
    end
  end

  assign o_rd0 = f_in_range(i_raddr0) ? r_mem[i_raddr0] : '0;
  assign o_rd1 = f_in_range(i_raddr1) ? r_mem[i_raddr1] : '0;
  assign o_rd2 = f_in_range(i_raddr2) ? r_mem[i_raddr2] : '0;

endmodule
`default_nettype wire

// File: rtl/ram2_responder.sv
`default_nettype none
// ============================================================================
// Module  : ram2_responder
// Purpose : Memory-side responder: two registered read ports, one functional
//           write port, debug load/inspect, hardware clear sequencer, sticky
//           collision/address-error flags and saturating write/drop counters.
// Rev     : 1.0  initial release
// ============================================================================
module ram2_responder
  import ram2_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W,
  parameter int DATA_W = C_DATA_W,
  parameter int DEPTH  = C_DEPTH,
  parameter int BYPASS = 0,
  parameter int CNT_W  = C_CNT_W   // 1..32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wen,
  input  logic [ADDR_W-1:0] debug_write_addr,
  input  logic [DATA_W-1:0] debug_write_data,
  input  logic              debug_write_en,
  input  logic [ADDR_W-1:0] debug_addr,
  output logic [DATA_W-1:0] debug_data,
  input  logic              init_req,
  output logic              busy,
  output logic              collision,
  output logic              addr_err,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  drop_count
);

  localparam logic [ADDR_W:0]   c_depth_ext = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_last_ptr  = ADDR_W'(DEPTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_ptr;
  logic [ADDR_W-1:0]  w_ptr_nxt;
  logic [DATA_W-1:0]  r_rdata0;
  logic [DATA_W-1:0]  r_rdata1;
  logic               r_collision;
  logic               r_addr_err;
  logic [CNT_W-1:0]   r_wr_count;
  logic [CNT_W-1:0]   r_drop_count;

  logic               w_busy;
  logic               w_fn_in_range;
  logic               w_dbg_in_range;
  logic [1:0]         w_rd_in_range;
  logic               w_fn_ok;
  logic               w_fn_drop;
  logic               w_dbg_ok;
  logic               w_collide;
  logic               w_addr_bad;
  logic [ADDR_W-1:0]  w_raddr   [2];
  logic [DATA_W-1:0]  w_tap     [2];
  logic [DATA_W-1:0]  w_rd_next [2];

  assign w_busy         = (r_state == CLEAR);
  assign w_fn_in_range  = ({1'b0, waddr} < c_depth_ext);
  assign w_dbg_in_range = ({1'b0, debug_write_addr} < c_depth_ext);
  assign w_rd_in_range  = {({1'b0, raddr1} < c_depth_ext), ({1'b0, raddr0} < c_depth_ext)};

  // Functional writes only land when out of reset, not clearing and in range
  assign w_fn_ok   = wen && !rst && !w_busy && w_fn_in_range;
  assign w_fn_drop = wen && (w_busy || !w_fn_in_range);
  assign w_dbg_ok  = debug_write_en && w_dbg_in_range;
  assign w_collide = wen && debug_write_en && (waddr == debug_write_addr);
  assign w_addr_bad = !w_rd_in_range[0] || !w_rd_in_range[1]
                    || (wen && !w_fn_in_range)
                    || (debug_write_en && !w_dbg_in_range);

  assign w_raddr[0] = raddr0;
  assign w_raddr[1] = raddr1;

  ram2_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk        (clk),
    .i_dbg_en   (w_dbg_ok),
    .i_dbg_addr (debug_write_addr),
    .i_dbg_data (debug_write_data),
    .i_clr_en   (w_busy),
    .i_clr_addr (r_ptr),
    .i_fn_en    (w_fn_ok),
    .i_fn_addr  (waddr),
    .i_fn_data  (wdata),
    .i_raddr0   (raddr0),
    .i_raddr1   (raddr1),
    .i_raddr2   (debug_addr),
    .o_rd0      (w_tap[0]),
    .o_rd1      (w_tap[1]),
    .o_rd2      (debug_data)
  );

  // Read data selection: stored word, or (bypass) the word being written now,
  // resolved in the same priority order the array uses.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      w_rd_next[n] = w_tap[n];
      if (BYPASS != 0) begin
        if (w_fn_ok && (waddr == w_raddr[n])) w_rd_next[n] = wdata;
        if (w_busy && (r_ptr == w_raddr[n])) w_rd_next[n] = '0;
        if (w_dbg_ok && (debug_write_addr == w_raddr[n])) w_rd_next[n] = debug_write_data;
      end
      if (!w_rd_in_range[n]) w_rd_next[n] = '0;
    end
  end

  // Registered read ports, one cycle latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_rdata0 <= w_rd_next[0];
      r_rdata1 <= w_rd_next[1];
    end
  end

  // Clear sequencer state and pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Clear sequencer next state: one word per cycle, back to idle after the last
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (init_req) begin
          w_state_nxt = CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        if (r_ptr == c_last_ptr) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // Sticky status flags, cleared only by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_collision <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_collision <= r_collision || w_collide;
      r_addr_err  <= r_addr_err || w_addr_bad;
    end
  end

  // Saturating accepted/dropped functional write counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_count   <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_fn_ok) r_wr_count <= CNT_W'(sat_inc(32'(r_wr_count), CNT_W));
      if (w_fn_drop) r_drop_count <= CNT_W'(sat_inc(32'(r_drop_count), CNT_W));
    end
  end

  assign rdata0     = r_rdata0;
  assign rdata1     = r_rdata1;
  assign busy       = w_busy;
  assign collision  = r_collision;
  assign addr_err   = r_addr_err;
  assign wr_count   = r_wr_count;
  assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_ram2_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram2_responder
// Purpose : Self-checking bench for ram2_responder. Three instances share the
//           stimulus: (BYPASS=0,DEPTH=32), (BYPASS=1,DEPTH=32) and
//           (BYPASS=0,DEPTH=20,CNT_W=3). A word-level reference model tracks
//           each one; directed tables/sequences add fixed expectations.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ram2_responder;

  localparam int NI = 3;
  int P_DEPTH [NI] = '{32, 32, 20};
  int P_BYP   [NI] = '{0, 1, 0};
  int P_CMAX  [NI] = '{65535, 65535, 7};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  raddr0 = '0, raddr1 = '0, waddr = '0, dwa = '0, da = '0;
  logic [31:0] wdata = '0, dwd = '0;
  logic        wen = 1'b0, dwe = 1'b0, init_req = 1'b0;

  logic [31:0] rd0 [NI];
  logic [31:0] rd1 [NI];
  logic [31:0] dd  [NI];
  logic        busy [NI];
  logic        coll [NI];
  logic        aerr [NI];
  logic [15:0] wc0, wc1, dc0, dc1;
  logic [2:0]  wc2, dc2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram2_responder #(.BYPASS(0)) u0 (
    .clk(clk), .rst(rst), .raddr0(raddr0), .rdata0(rd0[0]), .raddr1(raddr1), .rdata1(rd1[0]),
    .waddr(waddr), .wdata(wdata), .wen(wen), .debug_write_addr(dwa), .debug_write_data(dwd),
    .debug_write_en(dwe), .debug_addr(da), .debug_data(dd[0]), .init_req(init_req),
    .busy(busy[0]), .collision(coll[0]), .addr_err(aerr[0]), .wr_count(wc0), .drop_count(dc0));

  ram2_responder #(.BYPASS(1)) u1 (
    .clk(clk), .rst(rst), .raddr0(raddr0), .rdata0(rd0[1]), .raddr1(raddr1), .rdata1(rd1[1]),
    .waddr(waddr), .wdata(wdata), .wen(wen), .debug_write_addr(dwa), .debug_write_data(dwd),
    .debug_write_en(dwe), .debug_addr(da), .debug_data(dd[1]), .init_req(init_req),
    .busy(busy[1]), .collision(coll[1]), .addr_err(aerr[1]), .wr_count(wc1), .drop_count(dc1));

  ram2_responder #(.BYPASS(0), .DEPTH(20), .CNT_W(3)) u2 (
    .clk(clk), .rst(rst), .raddr0(raddr0), .rdata0(rd0[2]), .raddr1(raddr1), .rdata1(rd1[2]),
    .waddr(waddr), .wdata(wdata), .wen(wen), .debug_write_addr(dwa), .debug_write_data(dwd),
    .debug_write_en(dwe), .debug_addr(da), .debug_data(dd[2]), .init_req(init_req),
    .busy(busy[2]), .collision(coll[2]), .addr_err(aerr[2]), .wr_count(wc2), .drop_count(dc2));

  // ---------------- reference model (word-level) ----------------
  logic [31:0] m_mem [NI][32];
  logic [31:0] m_rd0 [NI];
  logic [31:0] m_rd1 [NI];
  bit          m_busy [NI];
  int          m_ptr  [NI];
  bit          m_coll [NI];
  bit          m_aerr [NI];
  int          m_wr   [NI];
  int          m_drop [NI];

  task automatic model_reset();
    for (int p = 0; p < NI; p++) begin
      m_rd0[p] = '0; m_rd1[p] = '0; m_busy[p] = 0; m_ptr[p] = 0;
      m_coll[p] = 0; m_aerr[p] = 0; m_wr[p] = 0; m_drop[p] = 0;
    end
  endtask

  // One clock edge: build the post-edge memory image, then derive reads,
  // flags, counters and clear progress from the pre-edge state and inputs.
  task automatic model_step();
    logic [31:0] nm [32];
    int d;
    for (int p = 0; p < NI; p++) begin
      d = P_DEPTH[p];
      for (int i = 0; i < 32; i++) nm[i] = m_mem[p][i];
      if (!rst) begin
        if (wen && int'(waddr) < d && !m_busy[p]) nm[waddr] = wdata;
        if (m_busy[p]) nm[m_ptr[p]] = '0;
      end
      if (dwe && int'(dwa) < d) nm[dwa] = dwd;
      if (!rst) begin
        if (int'(raddr0) >= d) m_rd0[p] = '0;
        else m_rd0[p] = P_BYP[p] != 0 ? nm[raddr0] : m_mem[p][raddr0];
        if (int'(raddr1) >= d) m_rd1[p] = '0;
        else m_rd1[p] = P_BYP[p] != 0 ? nm[raddr1] : m_mem[p][raddr1];
        if (int'(raddr0) >= d || int'(raddr1) >= d || (wen && int'(waddr) >= d) ||
            (dwe && int'(dwa) >= d)) m_aerr[p] = 1;
        if (wen && dwe && waddr == dwa) m_coll[p] = 1;
        if (wen) begin
          if (m_busy[p] || int'(waddr) >= d) begin
            if (m_drop[p] < P_CMAX[p]) m_drop[p]++;
          end else if (m_wr[p] < P_CMAX[p]) m_wr[p]++;
        end
        if (m_busy[p]) begin
          m_ptr[p]++;
          if (m_ptr[p] == d) begin m_busy[p] = 0; m_ptr[p] = 0; end
        end else if (init_req) begin
          m_busy[p] = 1; m_ptr[p] = 0;
        end
      end
      for (int i = 0; i < 32; i++) m_mem[p][i] = nm[i];
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] get_wc(input int p);
    case (p)
      0: return {16'b0, wc0};
      1: return {16'b0, wc1};
      default: return {29'b0, wc2};
    endcase
  endfunction

  function automatic logic [31:0] get_dc(input int p);
    case (p)
      0: return {16'b0, dc0};
      1: return {16'b0, dc1};
      default: return {29'b0, dc2};
    endcase
  endfunction

  task automatic check_all();
    logic [31:0] exp_dd;
    for (int p = 0; p < NI; p++) begin
      exp_dd = (int'(da) < P_DEPTH[p]) ? m_mem[p][da] : 32'h0;
      check($sformatf("u%0d.rdata0", p), rd0[p], m_rd0[p]);
      check($sformatf("u%0d.rdata1", p), rd1[p], m_rd1[p]);
      check($sformatf("u%0d.debug_data", p), dd[p], exp_dd);
      check($sformatf("u%0d.busy", p), 32'(busy[p]), 32'(m_busy[p]));
      check($sformatf("u%0d.collision", p), 32'(coll[p]), 32'(m_coll[p]));
      check($sformatf("u%0d.addr_err", p), 32'(aerr[p]), 32'(m_aerr[p]));
      check($sformatf("u%0d.wr_count", p), get_wc(p), 32'(m_wr[p]));
      check($sformatf("u%0d.drop_count", p), get_dc(p), 32'(m_drop[p]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic assert_rst();
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
  endtask

  typedef struct {
    logic [4:0]  ra0, ra1, dad;
    logic [31:0] e0, e1, ed;
  } vec_t;
  vec_t tbl [5];

  int bcnt [NI];

  initial begin
    // Read-only vectors against the i+1 preload (instance u0)
    tbl[0] = '{5'd10, 5'd0,  5'd10, 32'd11, 32'd1,  32'd11};
    tbl[1] = '{5'd0,  5'd31, 5'd31, 32'd1,  32'd32, 32'd32};
    tbl[2] = '{5'd31, 5'd5,  5'd0,  32'd32, 32'd6,  32'd1};
    tbl[3] = '{5'd20, 5'd19, 5'd19, 32'd21, 32'd20, 32'd20};
    tbl[4] = '{5'd7,  5'd7,  5'd3,  32'd8,  32'd8,  32'd4};

    // Reset state
    #1;
    assert_rst();
    for (int p = 0; p < NI; p++) begin
      check($sformatf("rst u%0d.rdata0", p), rd0[p], 32'h0);
      check($sformatf("rst u%0d.busy", p), 32'(busy[p]), 32'h0);
      check($sformatf("rst u%0d.wr_count", p), get_wc(p), 32'h0);
    end

    // Debug preload during reset
    for (int i = 0; i < 32; i++) begin
      dwe = 1'b1; dwa = 5'(i); dwd = 32'(i + 1);
      tick();
    end
    dwe = 1'b0;
    da = 5'd10;
    #1;
    check("preload debug_data[10]", dd[0], 32'd11);
    rst = 1'b0;
    tick();

    // Table-driven reads
    for (int i = 0; i < 5; i++) begin
      raddr0 = tbl[i].ra0; raddr1 = tbl[i].ra1; da = tbl[i].dad;
      tick();
      check($sformatf("tbl%0d rdata0", i), rd0[0], tbl[i].e0);
      check($sformatf("tbl%0d rdata1", i), rd1[0], tbl[i].e1);
      check($sformatf("tbl%0d debug_data", i), dd[0], tbl[i].ed);
    end

    // Write and read the same address in one cycle
    wen = 1'b1; waddr = 5'd3; wdata = 32'd12; raddr0 = 5'd3;
    tick();
    check("wr+rd bypass0 old", rd0[0], 32'd4);
    check("wr+rd bypass1 new", rd0[1], 32'd12);
    wen = 1'b0;
    tick();
    check("wr+rd bypass0 next", rd0[0], 32'd12);
    check("wr_count after write", {16'b0, wc0}, 32'd1);

    // Debug and functional write collide at one address
    wen = 1'b1; waddr = 5'd5; wdata = 32'd7; dwe = 1'b1; dwa = 5'd5; dwd = 32'd9;
    tick();
    wen = 1'b0; dwe = 1'b0; da = 5'd5;
    check("collision flag", 32'(coll[0]), 32'd1);
    tick();
    check("collision debug wins", dd[0], 32'd9);
    check("collision wr_count", {16'b0, wc0}, 32'd2);

    // Clear sequence with a functional write dropped mid-clear
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    for (int p = 0; p < NI; p++) bcnt[p] = int'(busy[p]);
    for (int k = 0; k < 40; k++) begin
      if (k == 2) begin wen = 1'b1; waddr = 5'd0; wdata = 32'hdead; end
      else wen = 1'b0;
      tick();
      for (int p = 0; p < NI; p++) bcnt[p] += int'(busy[p]);
    end
    check("busy cycles depth32", 32'(bcnt[0]), 32'd32);
    check("busy cycles depth20", 32'(bcnt[2]), 32'd20);
    check("clear drop_count", {16'b0, dc0}, 32'd1);
    for (int a = 0; a < 32; a++) begin
      da = 5'(a);
      #1;
      check($sformatf("cleared mem[%0d]", a), dd[0], 32'h0);
    end

    // Reload, start clear, reset 10 cycles in
    for (int i = 0; i < 32; i++) begin
      dwe = 1'b1; dwa = 5'(i); dwd = 32'(i + 1);
      tick();
    end
    dwe = 1'b0; raddr0 = 5'd20;
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    repeat (10) tick();
    check("pre-rst rdata0", rd0[0], 32'd21);
    assert_rst();
    check("mid-clear rst busy", 32'(busy[0]), 32'h0);
    check("mid-clear rst rdata0", rd0[0], 32'h0);
    check("mid-clear rst collision", 32'(coll[0]), 32'h0);
    check("mid-clear rst wr_count", {16'b0, wc0}, 32'h0);
    check("mid-clear rst drop_count", {16'b0, dc0}, 32'h0);
    da = 5'd9;  #1; check("partial clear mem[9]", dd[0], 32'h0);
    da = 5'd10; #1; check("partial clear mem[10]", dd[0], 32'd11);
    da = 5'd31; #1; check("partial clear mem[31]", dd[0], 32'd32);
    tick();
    rst = 1'b0;
    tick();

    // Out-of-range functional write and read on the DEPTH=20 instance
    wen = 1'b1; waddr = 5'd25; wdata = 32'd1; raddr1 = 5'd25; raddr0 = 5'd0;
    tick();
    check("oor addr_err", 32'(aerr[2]), 32'd1);
    check("oor drop_count", {29'b0, dc2}, 32'd1);
    check("oor rdata1", rd1[2], 32'h0);
    check("in-range rdata1 depth32", rd1[0], 32'd26);
    repeat (9) tick();
    check("drop_count saturates", {29'b0, dc2}, 32'd7);
    wen = 1'b0;
    tick();

    // Randomised traffic against the model
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        if (!rst) assert_rst();
      end else begin
        rst = 1'b0;
      end
      wen      = 1'($urandom_range(0, 1));
      waddr    = 5'($urandom_range(0, 31));
      wdata    = $urandom;
      dwe      = ($urandom_range(0, 7) == 0);
      dwa      = 5'($urandom_range(0, 31));
      dwd      = $urandom;
      raddr0   = 5'($urandom_range(0, 31));
      raddr1   = 5'($urandom_range(0, 31));
      da       = 5'($urandom_range(0, 31));
      init_req = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
